// File: rtl/vm_pkg.sv
// rtl/vm_pkg.sv - shared types, item prices and currency constants for the vending session controller
package vm_pkg;

    localparam int NUM_ITEMS   = 10;
    localparam int MAX_CLIENTS = 100;
    localparam int CID_W       = $clog2(MAX_CLIENTS);

    localparam logic [1:0] CUR_BASE    = 2'd0;
    localparam logic [1:0] CUR_X90     = 2'd1;
    localparam logic [1:0] CUR_X100    = 2'd2;
    localparam logic [1:0] CUR_INVALID = 2'd3;

    localparam logic [6:0] RATE_BASE = 7'd1;
    localparam logic [6:0] RATE_X90  = 7'd90;
    localparam logic [6:0] RATE_X100 = 7'd100;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SESSION = 2'd1,
        ST_VEND    = 2'd2
    } state_t;

    typedef logic [15:0] price_t;

    localparam price_t PRICE [NUM_ITEMS] = '{
        16'd50, 16'd60, 16'd70, 16'd80, 16'd90,
        16'd100, 16'd110, 16'd120, 16'd130, 16'd140
    };

    // Selection is one-hot, so OR-ing the matching prices yields the single price
    function automatic price_t sel_price(input logic [NUM_ITEMS-1:0] sel);
        price_t p;
        p = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (sel[i]) begin
                p = p | PRICE[i];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/vm_coin_valuer.sv
// rtl/vm_coin_valuer.sv - converts a coin face value and currency type into base units
module vm_coin_valuer
    import vm_pkg::*;
(
    input  logic [5:0]  i_coin,
    input  logic [1:0]  i_currency,
    output logic [31:0] o_value,
    output logic        o_valid
);

    logic [6:0] w_rate;

    always_comb begin
        w_rate  = '0;
        o_valid = 1'b1;
        case (i_currency)
            CUR_BASE: w_rate = RATE_BASE;
            CUR_X90:  w_rate = RATE_X90;
            CUR_X100: w_rate = RATE_X100;
            default: begin
                w_rate  = '0;
                o_valid = 1'b0;
            end
        endcase
        o_value = 32'(i_coin) * 32'(w_rate);
    end

endmodule

// File: rtl/vending_session_ctrl.sv
// rtl/vending_session_ctrl.sv - sequences one purchase: client id, credit, selection, vend/refuse/refund
module vending_session_ctrl
    import vm_pkg::*;
#(
    parameter int TIMEOUT             = 1000,
    parameter int CHANGE_RESERVE_INIT = 5000,
    parameter int POINT_DIV           = 10
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_id_valid,
    input  logic [8:0]           i_client_id,
    input  logic [5:0]           i_coin_in,
    input  logic [1:0]           i_currency_type,
    input  logic                 i_coin_insert,
    input  logic [NUM_ITEMS-1:0] i_item_select,
    input  logic                 i_confirm,
    output logic [NUM_ITEMS-1:0] o_item_out,
    output logic [31:0]          o_change_out,
    output logic                 o_no_change,
    output logic [7:0]           o_client_points
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t               r_state;
    state_t               w_next_state;
    logic [CID_W-1:0]     r_client_id;
    logic [31:0]          r_credit;
    logic [31:0]          r_reserve;
    logic [NUM_ITEMS-1:0] r_sel;
    logic [TW-1:0]        r_timer;
    logic [7:0]           r_points [MAX_CLIENTS];
    logic [NUM_ITEMS-1:0] r_item_out;
    logic [31:0]          r_change_out;
    logic                 r_no_change;
    logic [7:0]           r_client_points;

    logic [31:0] w_coin_value;
    logic        w_coin_valid;
    logic [32:0] w_credit_sum;
    logic [31:0] w_credit_sat;
    price_t      w_price;
    logic [31:0] w_change;
    logic [7:0]  w_gain;
    logic [8:0]  w_points_sum;
    logic [7:0]  w_points_new;
    logic        w_id_ok;
    logic        w_activity;
    logic        w_timed_out;
    logic        w_confirm_eff;
    logic        w_short_reserve;
    logic        w_accept_id;
    logic        w_cancel;
    logic        w_vend;
    logic        w_refuse;
    logic        w_credit_coin;
    logic        w_take_sel;

    vm_coin_valuer u_coin_valuer (
        .i_coin     (i_coin_in),
        .i_currency (i_currency_type),
        .o_value    (w_coin_value),
        .o_valid    (w_coin_valid)
    );

    assign w_credit_sum    = {1'b0, r_credit} + {1'b0, w_coin_value};
    assign w_credit_sat    = w_credit_sum[32] ? '1 : w_credit_sum[31:0];
    assign w_price         = sel_price(r_sel);
    assign w_change        = r_credit - 32'(w_price);
    assign w_short_reserve = w_change > r_reserve;
    assign w_id_ok         = i_id_valid && (i_client_id < 9'(MAX_CLIENTS));
    assign w_activity      = i_id_valid | i_coin_insert | i_confirm | (|i_item_select);
    assign w_timed_out     = (r_timer == TW'(TIMEOUT - 1)) && !w_activity;
    // A coin in the same cycle wins over confirm
    assign w_confirm_eff   = i_confirm && !i_coin_insert;

    always_comb begin
        w_gain = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (r_sel[i]) begin
                w_gain = w_gain | 8'(PRICE[i] / POINT_DIV);
            end
        end
    end

    assign w_points_sum = {1'b0, r_points[r_client_id]} + {1'b0, w_gain};
    assign w_points_new = w_points_sum[8] ? 8'hFF : w_points_sum[7:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_id_ok) w_next_state = ST_SESSION;
            end
            ST_SESSION: begin
                if (w_timed_out) begin
                    w_next_state = ST_IDLE;
                end else if (w_confirm_eff) begin
                    if (r_sel == '0)                         w_next_state = ST_IDLE;
                    else if (r_credit >= 32'(w_price))       w_next_state = ST_VEND;
                end
            end
            ST_VEND: begin
                w_next_state = w_short_reserve ? ST_SESSION : ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_accept_id   = (r_state == ST_IDLE) && w_id_ok;
        w_cancel      = (r_state == ST_SESSION) &&
                        (w_timed_out || (w_confirm_eff && (r_sel == '0)));
        w_vend        = (r_state == ST_VEND) && !w_short_reserve;
        w_refuse      = (r_state == ST_VEND) && w_short_reserve;
        w_credit_coin = (r_state == ST_SESSION) && i_coin_insert && w_coin_valid;
        w_take_sel    = (r_state == ST_SESSION) && $onehot(i_item_select);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_client_id     <= '0;
            r_credit        <= '0;
            r_reserve       <= 32'(CHANGE_RESERVE_INIT);
            r_sel           <= '0;
            r_timer         <= '0;
            r_item_out      <= '0;
            r_change_out    <= '0;
            r_no_change     <= 1'b0;
            r_client_points <= '0;
            for (int i = 0; i < MAX_CLIENTS; i++) begin
                r_points[i] <= '0;
            end
        end else begin
            r_item_out  <= '0;
            r_no_change <= 1'b0;
            if (r_state == ST_SESSION) begin
                r_timer <= w_activity ? '0 : r_timer + TW'(1);
            end
            if (w_accept_id) begin
                r_client_id     <= i_client_id[CID_W-1:0];
                r_credit        <= '0;
                r_sel           <= '0;
                r_timer         <= '0;
                r_change_out    <= '0;
                r_client_points <= r_points[i_client_id[CID_W-1:0]];
            end
            if (w_credit_coin) r_credit <= w_credit_sat;
            if (w_take_sel)    r_sel    <= i_item_select;
            if (w_cancel) begin
                r_change_out <= r_credit;
                r_credit     <= '0;
            end
            if (w_refuse) begin
                r_no_change <= 1'b1;
                r_sel       <= '0;
                r_timer     <= '0;
            end
            if (w_vend) begin
                r_item_out               <= r_sel;
                r_change_out             <= w_change;
                r_credit                 <= '0;
                r_reserve                <= r_reserve + 32'(w_price);
                r_points[r_client_id]    <= w_points_new;
                r_client_points          <= w_points_new;
            end
        end
    end

    assign o_item_out      = r_item_out;
    assign o_change_out    = r_change_out;
    assign o_no_change     = r_no_change;
    assign o_client_points = r_client_points;

endmodule

// File: tb/tb_vending_session_ctrl.sv
// tb/tb_vending_session_ctrl.sv - directed self-checking bench for vending_session_ctrl
module tb_vending_session_ctrl;
    import vm_pkg::*;

    localparam int TB_TIMEOUT = 20;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 id_valid;
    logic [8:0]           client_id;
    logic [5:0]           coin_in;
    logic [1:0]           currency_type;
    logic                 coin_insert;
    logic [NUM_ITEMS-1:0] item_select;
    logic                 confirm;
    logic [NUM_ITEMS-1:0] item_out;
    logic [31:0]          change_out;
    logic                 no_change;
    logic [7:0]           client_points;

    int checks = 0;
    int errors = 0;

    vending_session_ctrl #(
        .TIMEOUT             (TB_TIMEOUT),
        .CHANGE_RESERVE_INIT (40),
        .POINT_DIV           (10)
    ) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_id_valid      (id_valid),
        .i_client_id     (client_id),
        .i_coin_in       (coin_in),
        .i_currency_type (currency_type),
        .i_coin_insert   (coin_insert),
        .i_item_select   (item_select),
        .i_confirm       (confirm),
        .o_item_out      (item_out),
        .o_change_out    (change_out),
        .o_no_change     (no_change),
        .o_client_points (client_points)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; id_valid = 1'b0; client_id = '0; coin_in = '0; currency_type = '0;
        coin_insert = 1'b0; item_select = '0; confirm = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_id(input int id);
        id_valid = 1'b1; client_id = 9'(id);
        tick();
        id_valid = 1'b0;
    endtask

    task automatic send_coin(input int value, input int ctype);
        coin_insert = 1'b1; coin_in = 6'(value); currency_type = 2'(ctype);
        tick();
        coin_insert = 1'b0;
    endtask

    task automatic send_sel(input int idx);
        item_select = '0;
        item_select[idx] = 1'b1;
        tick();
        item_select = '0;
    endtask

    task automatic send_confirm();
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
    endtask

    // Leaves the bench in the cycle where the dispense pulse should be visible
    task automatic purchase(input int id, input int idx, input int c100, input int c1);
        send_id(id);
        if (c100 != 0) send_coin(c100, 2);
        if (c1 != 0) send_coin(c1, 0);
        send_sel(idx);
        send_confirm();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++; if (item_out !== '0) begin errors++; $display("FAIL reset_item_out: got %h expected 0", item_out); end
        checks++; if (change_out !== 32'd0) begin errors++; $display("FAIL reset_change_out: got %0d expected 0", change_out); end
        checks++; if (no_change !== 1'b0) begin errors++; $display("FAIL reset_no_change: got %b expected 0", no_change); end
        checks++; if (client_points !== 8'd0) begin errors++; $display("FAIL reset_points: got %0d expected 0", client_points); end
    endtask

    task automatic test_basic_vend();
        apply_reset();
        send_id(5);
        send_coin(50, 0);
        send_coin(30, 0);
        send_sel(2);
        send_confirm();
        checks++; if (item_out !== '0) begin errors++; $display("FAIL basic_early_item: got %h expected 0", item_out); end
        tick();
        checks++; if (item_out !== 10'h004) begin errors++; $display("FAIL basic_item_out: got %h expected 004", item_out); end
        checks++; if (change_out !== 32'd10) begin errors++; $display("FAIL basic_change: got %0d expected 10", change_out); end
        checks++; if (client_points !== 8'd7) begin errors++; $display("FAIL basic_points: got %0d expected 7", client_points); end
        tick();
        checks++; if (item_out !== '0) begin errors++; $display("FAIL basic_pulse_width: got %h expected 0", item_out); end
        checks++; if (change_out !== 32'd10) begin errors++; $display("FAIL basic_change_hold: got %0d expected 10", change_out); end
    endtask

    task automatic test_foreign_currency();
        apply_reset();
        send_id(1);
        send_coin(5, 3);
        send_coin(1, 2);
        send_sel(3);
        send_confirm();
        tick();
        checks++; if (item_out !== 10'h008) begin errors++; $display("FAIL foreign_item_out: got %h expected 008", item_out); end
        checks++; if (change_out !== 32'd20) begin errors++; $display("FAIL foreign_change: got %0d expected 20", change_out); end
        send_id(1);
        checks++; if (change_out !== 32'd0) begin errors++; $display("FAIL foreign_change_clear: got %0d expected 0", change_out); end
        checks++; if (client_points !== 8'd8) begin errors++; $display("FAIL foreign_points_load: got %0d expected 8", client_points); end
        send_coin(1, 1);
        send_coin(5, 0);
        send_sel(4);
        send_confirm();
        tick();
        checks++; if (item_out !== 10'h010) begin errors++; $display("FAIL x90_item_out: got %h expected 010", item_out); end
        checks++; if (change_out !== 32'd5) begin errors++; $display("FAIL x90_change: got %0d expected 5", change_out); end
        checks++; if (client_points !== 8'd17) begin errors++; $display("FAIL x90_points: got %0d expected 17", client_points); end
    endtask

    task automatic test_insufficient_cancel();
        logic [NUM_ITEMS-1:0] seen;
        apply_reset();
        send_id(7);
        send_coin(40, 0);
        send_sel(0);
        send_confirm();
        seen = '0;
        for (int i = 0; i < TB_TIMEOUT - 1; i++) begin
            tick();
            seen = seen | item_out;
        end
        checks++; if (seen !== '0) begin errors++; $display("FAIL short_credit_vend: got %h expected 0", seen); end
        checks++; if (change_out !== 32'd0) begin errors++; $display("FAIL timeout_early: got %0d expected 0", change_out); end
        tick();
        checks++; if (change_out !== 32'd40) begin errors++; $display("FAIL timeout_refund: got %0d expected 40", change_out); end
        send_coin(60, 0);
        send_sel(0);
        send_confirm();
        tick();
        checks++; if (item_out !== '0 || change_out !== 32'd40) begin
            errors++; $display("FAIL idle_ignores: got item %h change %0d expected 0 and 40", item_out, change_out);
        end
        send_id(8);
        send_coin(20, 0);
        send_confirm();
        checks++; if (change_out !== 32'd20) begin errors++; $display("FAIL confirm_cancel: got %0d expected 20", change_out); end
    endtask

    task automatic test_change_refusal();
        apply_reset();
        send_id(2);
        send_coin(1, 2);
        send_sel(0);
        send_confirm();
        checks++; if (no_change !== 1'b0) begin errors++; $display("FAIL refuse_early: got %b expected 0", no_change); end
        tick();
        checks++; if (no_change !== 1'b1) begin errors++; $display("FAIL refuse_pulse: got %b expected 1", no_change); end
        checks++; if (item_out !== '0) begin errors++; $display("FAIL refuse_item: got %h expected 0", item_out); end
        tick();
        checks++; if (no_change !== 1'b0) begin errors++; $display("FAIL refuse_pulse_width: got %b expected 0", no_change); end
        send_coin(10, 0);
        send_sel(5);
        send_confirm();
        tick();
        checks++; if (item_out !== 10'h020) begin errors++; $display("FAIL retry_item_out: got %h expected 020", item_out); end
        checks++; if (change_out !== 32'd10) begin errors++; $display("FAIL retry_change: got %0d expected 10", change_out); end
        checks++; if (client_points !== 8'd10) begin errors++; $display("FAIL retry_points: got %0d expected 10", client_points); end
    endtask

    task automatic test_coin_with_confirm();
        logic [NUM_ITEMS-1:0] seen;
        apply_reset();
        send_id(3);
        send_coin(60, 0);
        send_sel(0);
        coin_insert = 1'b1; coin_in = 6'd10; currency_type = 2'd0; confirm = 1'b1;
        tick();
        coin_insert = 1'b0; confirm = 1'b0;
        seen = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | item_out;
        end
        checks++; if (seen !== '0) begin errors++; $display("FAIL coin_confirm_vend: got %h expected 0", seen); end
        send_confirm();
        tick();
        checks++; if (item_out !== 10'h001) begin errors++; $display("FAIL coin_confirm_item: got %h expected 001", item_out); end
        checks++; if (change_out !== 32'd20) begin errors++; $display("FAIL coin_confirm_change: got %0d expected 20", change_out); end
    endtask

    task automatic test_invalid_id();
        logic [NUM_ITEMS-1:0] seen;
        apply_reset();
        send_id(100);
        send_coin(50, 0);
        send_sel(0);
        send_confirm();
        seen = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | item_out;
        end
        checks++; if (seen !== '0) begin errors++; $display("FAIL bad_id_vend: got %h expected 0", seen); end
        purchase(99, 0, 0, 50);
        checks++; if (item_out !== 10'h001) begin errors++; $display("FAIL max_id_item: got %h expected 001", item_out); end
        checks++; if (client_points !== 8'd5) begin errors++; $display("FAIL max_id_points: got %0d expected 5", client_points); end
    endtask

    task automatic test_reset_in_vend();
        apply_reset();
        purchase(4, 0, 0, 50);
        send_id(4);
        checks++; if (client_points !== 8'd5) begin errors++; $display("FAIL rv_points_load: got %0d expected 5", client_points); end
        send_coin(60, 0);
        send_sel(0);
        send_confirm();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (item_out !== '0) begin errors++; $display("FAIL rv_item_out: got %h expected 0", item_out); end
        checks++; if (change_out !== 32'd0) begin errors++; $display("FAIL rv_change: got %0d expected 0", change_out); end
        checks++; if (client_points !== 8'd0) begin errors++; $display("FAIL rv_points: got %0d expected 0", client_points); end
        tick();
        checks++; if (item_out !== '0 || no_change !== 1'b0) begin
            errors++; $display("FAIL rv_late_pulse: got item %h no_change %b expected 0 0", item_out, no_change);
        end
        send_id(4);
        checks++; if (client_points !== 8'd0) begin errors++; $display("FAIL rv_table_clear: got %0d expected 0", client_points); end
    endtask

    task automatic test_points_saturation();
        apply_reset();
        for (int i = 0; i < 17; i++) begin
            purchase(6, 9, 1, 40);
        end
        checks++; if (client_points !== 8'd238) begin errors++; $display("FAIL sat_points_238: got %0d expected 238", client_points); end
        purchase(6, 7, 1, 20);
        checks++; if (client_points !== 8'd250) begin errors++; $display("FAIL sat_points_250: got %0d expected 250", client_points); end
        purchase(6, 9, 1, 40);
        checks++; if (item_out !== 10'h200) begin errors++; $display("FAIL sat_item_out: got %h expected 200", item_out); end
        checks++; if (client_points !== 8'd255) begin errors++; $display("FAIL sat_points_255: got %0d expected 255", client_points); end
    endtask

    initial begin
        rst = 1'b1; id_valid = 1'b0; client_id = '0; coin_in = '0; currency_type = '0;
        coin_insert = 1'b0; item_select = '0; confirm = 1'b0;
        test_reset();
        test_basic_vend();
        test_foreign_currency();
        test_insufficient_cancel();
        test_change_refusal();
        test_coin_with_confirm();
        test_invalid_id();
        test_reset_in_vend();
        test_points_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/vending_session_ctrl.md
# vending_session_ctrl

Session controller for the vending machine. It accepts a client ID, accumulates credit from inserted coins across currency types, and latches the item selection. On confirm it decides vend, refuse (insufficient change reserve) or refund. It drives the item, change, no-change and loyalty-point outputs. It sits directly behind the user-facing signal bundle and is the only block that sequences a purchase.

## Interface
- NUM_ITEMS, 10, number of selectable items.
- MAX_CLIENTS, 100, number of valid client IDs (0..MAX_CLIENTS-1).
- TIMEOUT, 1000, idle cycles in SESSION before automatic cancel.
- CHANGE_RESERVE_INIT, 5000, change reserve (base units) after reset.
- POINT_DIV, 10, base units of price per loyalty point.
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  client_id qualifier, single-cycle pulse.
- client_id  in  9  client number.
- coin_in  in  6  coin face value.
- currency_type  in  2  0=base (×1), 1=×90, 2=×100, 3=invalid.
- coin_insert  in  1  one coin per high cycle.
- item_select  in  NUM_ITEMS  one-hot item request.
- confirm  in  1  purchase/cancel request, single-cycle.
- item_out  out  NUM_ITEMS  one-hot dispense pulse.
- change_out  out  32  change amount in base units, held.
- no_change  out  1  pulse: vend refused, reserve too small.
- client_points  out  8  points of the current/last client.

## Operation
- States are IDLE, SESSION and VEND.
- IDLE:
  - id_valid with client_id < MAX_CLIENTS → SESSION. Latch the ID, clear credit and selection, clear change_out, load client_points from the points table.
  - client_id ≥ MAX_CLIENTS is ignored.
  - Coins, selects and confirms are ignored.
- SESSION:
  - Coin: coin_insert adds coin_in×rate(currency_type) to the 32-bit credit. Addition saturates at 2^32-1. currency_type 3 coins are ignored.
  - Selection: item_select with exactly one bit set replaces the latched selection. Zero or multi-hot values are ignored.
  - Confirm with a selection and credit ≥ PRICE[sel] → VEND.
  - Confirm with a selection and credit < PRICE[sel] → ignored.
  - Confirm with no selection → cancel.
  - Confirm in the same cycle as coin_insert: the coin is credited and the confirm is ignored.
  - Cancel: change_out = credit, credit cleared, → IDLE. The reserve is unchanged.
  - Timeout: any id_valid, coin_insert, confirm or nonzero item_select restarts the inactivity counter. Reaching TIMEOUT performs a cancel.
- VEND:
  - Compute change = credit − PRICE[sel].
  - change > reserve: pulse no_change, clear the selection, keep credit, → SESSION.
  - Otherwise:
    - Pulse item_out = selection.
    - change_out = change; credit cleared.
    - reserve += PRICE[sel].
    - points[id] += PRICE[sel]/POINT_DIV (integer divide), saturating at 255. client_points is updated to match.
    - → IDLE.
- Reset values:
  - State IDLE.
  - item_out, change_out, no_change and client_points = 0.
  - Credit 0, reserve CHANGE_RESERVE_INIT.
  - Entire points table cleared.

## Timing
- Coin credited to the internal credit register the cycle after coin_insert.
- Confirm sampled in SESSION at cycle N puts the state in VEND at N+1.
- At N+2:
  - item_out or no_change is high for exactly one cycle.
  - change_out and client_points take their new values.
  - State is IDLE (vend) or SESSION (refused).
- Cancel: confirm/timeout at N → change_out valid and state IDLE at N+1.
- change_out holds until the next accepted id_valid, which zeroes it the cycle after acceptance.
- Reset in any state returns everything to reset values on the next edge. A pending vend is discarded and no pulse is emitted.

## Structure
- Package vm_pkg:
  - NUM_ITEMS, MAX_CLIENTS.
  - State enum.
  - PRICE[NUM_ITEMS] as 16-bit values, PRICE[i] = 50 + 10·i.
  - Currency rate constants and the invalid-currency code.
- Sub-module vm_coin_valuer: combinational coin_in × rate → 32-bit value plus a valid flag. It is instantiated once.
- Points table: MAX_CLIENTS × 8 registers inside vending_session_ctrl, synchronously cleared on reset.

## Test plan
- Basic vend:
  - Stimulus: id 5; coins 50 and 30 (type 0); select item 2 (price 70); confirm.
  - Response: item_out=0x004 one cycle at N+2; change_out=10; client_points=7.
- Foreign currency:
  - Stimulus: id 1; one coin value 1 type 2 (=100); select item 3 (80); confirm.
  - Response: change_out=20; a type 3 coin inserted beforehand does not change credit.
- Insufficient credit, then cancel:
  - Stimulus: credit 40; select item 0 (50); confirm.
  - Response: no state change.
  - Stimulus: then confirm with selection cleared by reset-free re-entry, or wait TIMEOUT.
  - Response: change_out=40, state IDLE, no item_out.
- Change refusal:
  - Stimulus: reserve drained below 100; insert 1×type 2 (100); select item 0 (50); confirm.
  - Response: no_change pulse, item_out stays 0, credit still 100.
  - Stimulus: then insert 50×… so that change ≤ reserve.
  - Response: vend succeeds.
- Edge cases:
  - Stimulus: coin_insert and confirm in the same cycle.
  - Response: the coin is credited and no vend occurs.
  - Stimulus: client_id=100.
  - Response: ignored.
  - Stimulus: rst asserted in VEND.
  - Response: no item_out; all outputs 0 next cycle.
  - Stimulus: points at 250, purchase of price 140.
  - Response: client_points saturates at 255.
